// File: rtl/ccl_stack_unit_if.sv
// Fetch-side command/response bundle for ccl_stack_unit.
// The fetch stage drives the master side; the loop unit is the slave.
interface ccl_stack_unit_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [1:0]        command;
  logic [ADDR_W-1:0] address;
  logic [CNT_W-1:0]  counter;
  logic [ADDR_W-1:0] inTarget;
  logic [ADDR_W-1:0] outTarget;
  logic              valid;
  logic              taken;
  logic              error;
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;

  modport master (
    output command, address, counter, inTarget,
    input  outTarget, valid, taken, error, full, empty, level
  );

  modport slave (
    input  command, address, counter, inTarget,
    output outTarget, valid, taken, error, full, empty, level
  );
endinterface

// File: rtl/ccl_stack_unit.sv
// Counted-loop control unit: configurable-depth loop stack with a registered
// redirect response. Optional CCL_PERF_EN adds taken/error event counters.
module ccl_stack_unit #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  ccl_stack_unit_if.slave      bus
`ifdef CCL_PERF_EN
  ,
  output logic [31:0]          taken_count,
  output logic [31:0]          error_count
`endif
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_LOOP  = 2'b01,
    CMD_BREAK = 2'b10,
    CMD_FLUSH = 2'b11
  } cmd_e;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [CNT_W-1:0]  r_rem  [DEPTH];
  logic [LVL_W-1:0]  r_level;
  logic              r_valid;
  logic              r_taken;
  logic              r_error;
  logic [ADDR_W-1:0] r_target;

  cmd_e              w_cmd;
  logic              w_empty;
  logic              w_full;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_match;
  logic              w_push;
  logic              w_pop;
  logic              w_dec;
  logic              w_flush;
  logic              w_valid;
  logic              w_taken;
  logic              w_error;
  logic              w_load;

  assign w_cmd   = cmd_e'(bus.command);
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_W'(DEPTH));
  // Top index is forced to 0 when empty so the read never leaves the array.
  assign w_top_idx = w_empty ? '0 : IDX_W'(r_level - LVL_W'(1));
  assign w_wr_idx  = IDX_W'(r_level);
  assign w_match   = !w_empty && (bus.address == r_addr[w_top_idx]);

  always_comb begin
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_dec   = 1'b0;
    w_flush = 1'b0;
    w_valid = 1'b0;
    w_taken = 1'b0;
    w_error = 1'b0;
    w_load  = 1'b0;
    unique case (w_cmd)
      CMD_LOOP: begin
        if (w_match) begin
          w_valid = 1'b1;
          if (r_rem[w_top_idx] == '0) begin
            w_pop = 1'b1;
          end else begin
            w_dec   = 1'b1;
            w_taken = 1'b1;
            w_load  = 1'b1;
          end
        end else if (bus.counter == '0) begin
          w_error = 1'b1;
        end else if (bus.counter == CNT_W'(1)) begin
          w_valid = 1'b1;
        end else if (!w_full) begin
          w_push  = 1'b1;
          w_valid = 1'b1;
          w_taken = 1'b1;
          w_load  = 1'b1;
        end else begin
          w_error = 1'b1;
        end
      end
      CMD_BREAK: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_valid = 1'b1;
          w_taken = 1'b1;
          w_load  = 1'b1;
        end else begin
          w_error = 1'b1;
        end
      end
      CMD_FLUSH: begin
        w_flush = 1'b1;
        w_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_taken  <= 1'b0;
      r_error  <= 1'b0;
      r_target <= '0;
    end else begin
      r_valid <= w_valid;
      r_taken <= w_taken;
      r_error <= w_error;
      if (w_load) r_target <= bus.inTarget;
      if (w_flush)     r_level <= '0;
      else if (w_push) r_level <= r_level + LVL_W'(1);
      else if (w_pop)  r_level <= r_level - LVL_W'(1);
    end
  end

  // Entry payloads are intentionally unreset; only level defines validity.
  // Push stores counter-2: the first body pass and this redirect are already spent.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_push) begin
        r_addr[w_wr_idx] <= bus.address;
        r_rem[w_wr_idx]  <= bus.counter - CNT_W'(2);
      end else if (w_dec) begin
        r_rem[w_top_idx] <= r_rem[w_top_idx] - CNT_W'(1);
      end
    end
  end

`ifdef CCL_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      taken_count <= '0;
      error_count <= '0;
    end else begin
      if (w_valid && w_taken) taken_count <= taken_count + 32'd1;
      if (w_error)            error_count <= error_count + 32'd1;
    end
  end
`endif

  assign bus.outTarget = r_target;
  assign bus.valid     = r_valid;
  assign bus.taken     = r_taken;
  assign bus.error     = r_error;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.level     = r_level;
endmodule

// File: tb/tb_ccl_stack_unit.sv
// Directed, table-driven bench for ccl_stack_unit at DEPTH=4.
module tb_ccl_stack_unit;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;

  localparam logic [1:0] NOP = 2'b00, LOOP = 2'b01, BRK = 2'b10, FLS = 2'b11;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ccl_stack_unit_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

`ifdef CCL_PERF_EN
  logic [31:0] taken_count;
  logic [31:0] error_count;
`endif

  ccl_stack_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus)
`ifdef CCL_PERF_EN
    ,
    .taken_count (taken_count),
    .error_count (error_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic [31:0] tgt;
    logic        e_valid;
    logic        e_taken;
    logic        e_error;
    logic [31:0] e_tgt;
    int unsigned e_level;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [31:0] cnt, input logic [31:0] tgt);
    @(negedge clock);
    reset        = rst;
    bus.command  = cmd;
    bus.address  = addr;
    bus.counter  = cnt;
    bus.inTarget = tgt;
    @(posedge clock);
    @(negedge clock);
    reset       = 1'b0;
    bus.command = NOP;
  endtask

  task automatic add(input logic rst, input logic [1:0] cmd, input logic [31:0] addr,
                     input logic [31:0] cnt, input logic [31:0] tgt,
                     input logic v, input logic t, input logic e, input logic [31:0] et,
                     input int unsigned lvl, input logic f, input logic em);
    vec_t x;
    x.rst = rst; x.cmd = cmd; x.addr = addr; x.cnt = cnt; x.tgt = tgt;
    x.e_valid = v; x.e_taken = t; x.e_error = e; x.e_tgt = et;
    x.e_level = lvl; x.e_full = f; x.e_empty = em;
    vecs.push_back(x);
  endtask

  initial begin
    int n_taken;
    bit done;
    bus.command = NOP; bus.address = '0; bus.counter = '0; bus.inTarget = '0;

    //   rst cmd   addr    cnt tgt      v  t  e  etgt    lvl f  em
    add(1, NOP,  32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 1);
    add(0, LOOP, 32'h100, 3, 32'h80,  1, 1, 0, 32'h80,  1, 0, 0);
    add(0, LOOP, 32'h100, 3, 32'h80,  1, 1, 0, 32'h80,  1, 0, 0);
    add(0, LOOP, 32'h100, 3, 32'h80,  1, 0, 0, 32'h80,  0, 0, 1);
    add(0, LOOP, 32'h300, 1, 32'h90,  1, 0, 0, 32'h80,  0, 0, 1);
    add(0, LOOP, 32'h300, 0, 32'h90,  0, 0, 1, 32'h80,  0, 0, 1);
    add(0, NOP,  32'h0,   0, 32'h99,  0, 0, 0, 32'h80,  0, 0, 1);
    add(0, BRK,  32'h0,   0, 32'h500, 0, 0, 1, 32'h80,  0, 0, 1);
    add(0, LOOP, 32'h10,  5, 32'h11,  1, 1, 0, 32'h11,  1, 0, 0);
    add(0, LOOP, 32'h20,  5, 32'h21,  1, 1, 0, 32'h21,  2, 0, 0);
    add(0, LOOP, 32'h30,  5, 32'h31,  1, 1, 0, 32'h31,  3, 0, 0);
    add(0, LOOP, 32'h40,  5, 32'h41,  1, 1, 0, 32'h41,  4, 1, 0);
    add(0, LOOP, 32'h50,  5, 32'h51,  0, 0, 1, 32'h41,  4, 1, 0);
    add(0, LOOP, 32'h40,  5, 32'h42,  1, 1, 0, 32'h42,  4, 1, 0);
    add(0, LOOP, 32'h30,  5, 32'h33,  0, 0, 1, 32'h42,  4, 1, 0);
    add(0, BRK,  32'h0,   0, 32'h200, 1, 1, 0, 32'h200, 3, 0, 0);
    add(0, BRK,  32'h0,   0, 32'h210, 1, 1, 0, 32'h210, 2, 0, 0);
    add(0, FLS,  32'h0,   0, 32'h220, 1, 0, 0, 32'h210, 0, 0, 1);
    add(0, LOOP, 32'h10,  2, 32'h700, 1, 1, 0, 32'h700, 1, 0, 0);
    add(0, LOOP, 32'h10,  2, 32'h701, 1, 0, 0, 32'h700, 0, 0, 1);
    add(0, LOOP, 32'hA,   4, 32'hA1,  1, 1, 0, 32'hA1,  1, 0, 0);
    add(0, LOOP, 32'hB,   4, 32'hB1,  1, 1, 0, 32'hB1,  2, 0, 0);
    add(0, LOOP, 32'hC,   4, 32'hC1,  1, 1, 0, 32'hC1,  3, 0, 0);
    add(1, LOOP, 32'hC,   4, 32'hEE,  0, 0, 0, 32'h0,   0, 0, 1);
    add(0, LOOP, 32'hC,   4, 32'hC2,  1, 1, 0, 32'hC2,  1, 0, 0);
    add(0, LOOP, 32'hC,   4, 32'hC3,  1, 1, 0, 32'hC3,  1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].cmd, vecs[i].addr, vecs[i].cnt, vecs[i].tgt);
      check("valid",     i, 32'(bus.valid),     32'(vecs[i].e_valid));
      check("taken",     i, 32'(bus.taken),     32'(vecs[i].e_taken));
      check("error",     i, 32'(bus.error),     32'(vecs[i].e_error));
      check("outTarget", i, bus.outTarget,      vecs[i].e_tgt);
      check("level",     i, 32'(bus.level),     vecs[i].e_level);
      check("full",      i, 32'(bus.full),      32'(vecs[i].e_full));
      check("empty",     i, 32'(bus.empty),     32'(vecs[i].e_empty));
    end

    // Counter N=4 must yield exactly 3 redirects, exiting on the 4th LOOP.
    apply(1, NOP, 0, 0, 0);
    n_taken = 0;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      apply(0, LOOP, 32'h900, 4, 32'h880);
      if (bus.valid && bus.taken) n_taken++;
      else done = 1;
    end
    check("seq_exit_seen", 100, 32'(done), 32'd1);
    check("seq_redirects", 100, 32'(n_taken), 32'd3);
    check("seq_level",     100, 32'(bus.level), 32'd0);

`ifdef CCL_PERF_EN
    apply(1, NOP, 0, 0, 0);
    check("perf_taken_rst", 200, taken_count, 32'd0);
    apply(0, LOOP, 32'h100, 3, 32'h80);
    apply(0, LOOP, 32'h100, 3, 32'h80);
    apply(0, LOOP, 32'h100, 3, 32'h80);
    apply(0, BRK,  32'h0,   0, 32'h500);
    apply(0, FLS,  32'h0,   0, 32'h0);
    check("perf_taken", 201, taken_count, 32'd2);
    check("perf_error", 201, error_count, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccl_stack_unit.md
# ccl_stack_unit

Parametrised counted-loop control unit with a configurable-depth loop stack and a one-cycle registered response. It sits beside the instruction fetch stage. The fetch stage sends a loop-end, break or flush command with the loop address, trip count and branch target. The unit answers whether to redirect fetch to the target. It is the successor of the fixed 16-entry, 32-bit counted-loop unit. It adds width and depth parameters, an explicit taken/fall-through result, a flush command and occupancy status.

## Interface
- DEPTH, 16, number of loop stack entries (≥2)
- ADDR_W, 32, width of address and target
- CNT_W, 32, width of trip counter
- LVL_W, $clog2(DEPTH+1), width of occupancy output (derived, not overridden)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- command  in  2  00 NOP, 01 LOOP, 10 BREAK, 11 FLUSH
- address  in  ADDR_W  address of the loop-end instruction
- counter  in  CNT_W  total body executions requested (LOOP only)
- inTarget  in  ADDR_W  redirect target (loop start for LOOP, exit for BREAK)
- outTarget  out  ADDR_W  registered redirect target
- valid  out  1  one-cycle response strobe
- taken  out  1  fetch must redirect to outTarget (qualified by valid)
- error  out  1  one-cycle illegal/overflow/underflow strobe
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- level  out  LVL_W  current stack occupancy

## Operation
- Each stack entry holds an address (ADDR_W) and a remaining count (CNT_W).
- Only the top entry (index level-1) is compared.
- NOP: valid=0, taken=0, error=0. Stack unchanged. outTarget holds its value.
- LOOP with !empty and address == top.address (continue):
  - top.remaining == 0: pop. valid=1, taken=0 (loop exits).
  - otherwise: top.remaining -= 1. valid=1, taken=1, outTarget=inTarget.
- LOOP with empty, or address != top.address (new loop):
  - counter == 0: error=1, valid=0, taken=0. No push.
  - counter == 1: valid=1, taken=0. No push (body already ran once).
  - counter ≥ 2 and !full: push {address, counter-2}. valid=1, taken=1, outTarget=inTarget.
  - counter ≥ 2 and full: overflow. error=1, valid=0, taken=0. Stack unchanged.
- Net effect: a LOOP with counter N runs the body N times and takes N-1 redirects.
- BREAK:
  - !empty: pop. valid=1, taken=1, outTarget=inTarget.
  - empty: error=1, valid=0, taken=0.
- FLUSH: level←0. valid=1, taken=0, error=0.
- Arithmetic: remaining is an unsigned CNT_W value. Decrement happens only when the value is nonzero, so it never wraps. Level never exceeds DEPTH or goes below 0.
- Stack entry contents are not reset; only level is reset. Entries at or above level are don't-care.

## Timing
- Command is sampled on the rising edge. valid, taken, error and outTarget are registered and visible in the cycle after the command (latency 1).
- Back-to-back commands are accepted every cycle. There is no stall or handshake.
- A LOOP that immediately follows a push for the same address compares against the newly pushed entry.
- full, empty and level are decoded from the registered level and reflect all commands up to the previous edge.
- reset=1 on an edge overrides any command. The command is ignored with no error.
  - After reset: level=0, valid=0, taken=0, error=0, outTarget=0, full=0, empty=1.
- Reset asserted mid-loop discards all nesting. The first LOOP after reset is always treated as a new loop.

## Configuration
- CCL_PERF_EN defined: adds two output ports.
  - taken_count (32 bits): increments on every valid&&taken response.
  - error_count (32 bits): increments on every error strobe.
  - Both wrap modulo 2^32, are cleared only by reset, and are unaffected by FLUSH.
- CCL_PERF_EN undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- After reset: LOOP address=0x100, counter=3, inTarget=0x80, then LOOP 0x100 twice more.
  - Required: taken=1 (outTarget=0x80, level=1), then taken=1 (level=1), then taken=0 (level=0, empty=1).
- LOOP counter=1: valid=1, taken=0, level stays 0. LOOP counter=0: error=1, valid=0.
- DEPTH=4: push 4 nested loops (addresses 0x10–0x40, counter=5).
  - Required: full=1, level=4. A fifth LOOP at 0x50 gives error=1 with level still 4.
- BREAK on empty gives error=1. Push 2 loops, then BREAK inTarget=0x200: taken=1, outTarget=0x200, level=1. FLUSH then gives level=0, valid=1, taken=0.
- Push 3 loops, then assert reset together with command=01.
  - Required: next cycle valid=0, error=0, level=0, outTarget=0. A following LOOP at the old top address pushes a new entry.
- With CCL_PERF_EN: the first scenario followed by one BREAK on empty gives taken_count=2, error_count=1.
